spi_cmd_master: RTL

SPI_CMD_MASTER -- requirements
Module: spi_cmd_master

---
 rtl/spi_cmd_master_pkg.sv | 30 +++
 rtl/spi_half_period_timer.sv | 38 +++
 rtl/spi_cmd_master.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_master_pkg.sv
// Shared definitions for the SPI command link: default widths, the read
// opcode, FSM state encodings and timer load selects.
package spi_cmd_master_pkg;

    localparam int CMD_BIT_NUM_DEF   = 41;
    localparam int REPLY_BIT_NUM_DEF = 6;

    // Low nibble of a command word that turns it into a read
    localparam logic [3:0] READ_OPCODE = 4'b1000;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        BIT_LOW  = 3'd2,
        BIT_HIGH = 3'd3,
        CS_HOLD  = 3'd4,
        CS_IDLE  = 3'd5
    } spi_state_e;

    // Countdown reload selects for the half-period timer
    localparam logic [1:0] TMR_NOW  = 2'd0;  // expire on the very next cycle
    localparam logic [1:0] TMR_HALF = 2'd1;  // one SPI half period
    localparam logic [1:0] TMR_GAP  = 2'd2;  // CS setup / hold / idle gap

    // Limit a requested bit count to what the command register can hold
    function automatic logic [6:0] clamp_len(input logic [6:0] len, input int max_len);
        return (int'(len) > max_len) ? 7'(max_len) : len;
    endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// Shared countdown for every timed FSM state. A load of N-1 makes the
// following state last exactly N cycles; tick marks its final cycle.
module spi_half_period_timer
    import spi_cmd_master_pkg::*;
#(
    parameter int HALF_PERIOD = 16,
    parameter int CS_GAP      = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [1:0] sel,
    output logic       tick
);

    logic [7:0] cnt;
    logic [7:0] load_val;

    // Pick the reload value for the state being entered
    always_comb begin
        load_val = 8'd0;
        case (sel)
            TMR_HALF: load_val = 8'(HALF_PERIOD - 1);
            TMR_GAP:  load_val = 8'(CS_GAP - 1);
            default:  load_val = 8'd0;
        endcase
    end

    // Count down and park at zero so an idle timer never wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              cnt <= 8'd0;
        else if (load)         cnt <= load_val;
        else if (cnt != 8'd0)  cnt <= cnt - 8'd1;
    end

    assign tick = (cnt == 8'd0);

endmodule

// File: rtl/spi_cmd_master.sv
// SPI command master: shifts a command word out LSB first and, for read
// opcodes, clocks in a fixed-length reply. Pin outputs are registered off
// the next state so they never glitch.
module spi_cmd_master
    import spi_cmd_master_pkg::*;
#(
    parameter int CMD_BIT_NUM   = CMD_BIT_NUM_DEF,
    parameter int REPLY_BIT_NUM = REPLY_BIT_NUM_DEF,
    parameter int HALF_PERIOD   = 16,
    parameter int CS_GAP        = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CMD_BIT_NUM-1:0]   cmd_data,
    input  logic [6:0]               cmd_len,
    output logic                     busy,
    output logic                     done,
    output logic [REPLY_BIT_NUM-1:0] reply,
    output logic                     reply_valid,
    output logic                     spi_clk,
    output logic                     spi_cs,
    output logic                     spi_mosi,
    input  logic                     spi_miso
);

    // A read sends the 4-bit opcode then clocks the reply
    localparam logic [6:0] RD_TOTAL = 7'(4 + REPLY_BIT_NUM);

    spi_state_e             state, state_nxt;
    logic [CMD_BIT_NUM-1:0] cmd_sr;
    logic [6:0]             cmd_bits;     // bits driven from cmd_sr
    logic [6:0]             total_bits;   // all SPI clock cycles
    logic [6:0]             bit_cnt, bit_cnt_nxt;
    logic                   is_read;
    logic                   tick, tmr_load;
    logic [1:0]             tmr_sel;
    logic                   miso_s1, miso_s2;
    logic [6:0]             len_c;
    logic                   rd_dec, accept, enter_low, last_bit, reply_bit;

    assign len_c     = clamp_len(cmd_len, CMD_BIT_NUM);
    assign rd_dec    = (cmd_len >= 7'd4) && (cmd_data[3:0] == READ_OPCODE);
    assign accept    = (state == IDLE) && start;
    assign last_bit  = (bit_cnt + 7'd1 == total_bits);
    assign reply_bit = is_read && (bit_cnt >= 7'd4);
    assign enter_low = (state_nxt == BIT_LOW) && (state != BIT_LOW);

    spi_half_period_timer #(
        .HALF_PERIOD (HALF_PERIOD),
        .CS_GAP      (CS_GAP)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .sel  (tmr_sel),
        .tick (tick)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state, timer reloads and bit counting
    always_comb begin
        state_nxt   = state;
        tmr_load    = 1'b0;
        tmr_sel     = TMR_HALF;
        bit_cnt_nxt = bit_cnt;
        case (state)
            IDLE: if (start) begin
                tmr_load    = 1'b1;
                bit_cnt_nxt = 7'd0;
                if (len_c == 7'd0) begin
                    // nothing to send: skip the bus and finish next cycle
                    state_nxt = CS_IDLE;
                    tmr_sel   = TMR_NOW;
                end else begin
                    state_nxt = CS_SETUP;
                    tmr_sel   = TMR_GAP;
                end
            end
            CS_SETUP: if (tick) begin
                state_nxt = BIT_LOW;
                tmr_load  = 1'b1;
            end
            BIT_LOW: if (tick) begin
                state_nxt = BIT_HIGH;
                tmr_load  = 1'b1;
            end
            BIT_HIGH: if (tick) begin
                tmr_load    = 1'b1;
                bit_cnt_nxt = bit_cnt + 7'd1;
                if (last_bit) begin
                    state_nxt = CS_HOLD;
                    tmr_sel   = TMR_GAP;
                end else begin
                    state_nxt = BIT_LOW;
                end
            end
            CS_HOLD: if (tick) begin
                state_nxt = CS_IDLE;
                tmr_load  = 1'b1;
                tmr_sel   = TMR_GAP;
            end
            CS_IDLE: if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Two-flop synchronizer for the asynchronous reply line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
        end else begin
            miso_s1 <= spi_miso;
            miso_s2 <= miso_s1;
        end
    end

    // SPI pins, registered from the state being entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spi_cs   <= 1'b1;
            spi_clk  <= 1'b1;
            spi_mosi <= 1'b0;
        end else begin
            spi_cs  <= !(state_nxt inside {CS_SETUP, BIT_LOW, BIT_HIGH, CS_HOLD});
            spi_clk <= (state_nxt != BIT_LOW);
            // data moves only on the falling clock; reply bits send zero
            if (enter_low)
                spi_mosi <= (bit_cnt_nxt < cmd_bits) ? cmd_sr[0] : 1'b0;
            else if (state_nxt == CS_HOLD)
                spi_mosi <= 1'b0;
        end
    end

    // Command latch, shift register, reply capture and handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_sr      <= '0;
            cmd_bits    <= 7'd0;
            total_bits  <= 7'd0;
            bit_cnt     <= 7'd0;
            is_read     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            reply       <= '0;
            reply_valid <= 1'b0;
        end else begin
            done    <= 1'b0;
            bit_cnt <= bit_cnt_nxt;
            if (accept) begin
                cmd_sr      <= cmd_data;
                cmd_bits    <= rd_dec ? 7'd4 : len_c;
                total_bits  <= rd_dec ? RD_TOTAL : len_c;
                is_read     <= rd_dec;
                busy        <= 1'b1;
                reply_valid <= 1'b0;
            end else if (enter_low) begin
                cmd_sr <= cmd_sr >> 1;
            end
            // sample at the end of the high phase, filling from the MSB
            if (state == BIT_HIGH && tick && reply_bit)
                reply <= REPLY_BIT_NUM'({miso_s2, reply} >> 1);
            if (state == CS_IDLE && tick) begin
                done        <= 1'b1;
                busy        <= 1'b0;
                reply_valid <= is_read;
            end
        end
    end

endmodule
